// File: rtl/fixed_point_alu.sv
// Multi-cycle signed fixed-point unit: saturating ADD/SUB, chunked MUL, bit-serial SQRT.
// Start/busy/done handshake; one MUL_CHUNK x MUL_CHUNK multiplier shared across all partials.
module fixed_point_alu #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned FBITS     = 10,
  parameter int unsigned MUL_CHUNK = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       operation,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             overflow,
  output logic             error
);

  localparam int unsigned N    = WIDTH / MUL_CHUNK;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned R    = ((WIDTH + FBITS + 1) / 2) * 2;
  localparam int unsigned H    = R / 2;
  localparam int unsigned RemW = H + 2;
  localparam int unsigned CntW = $clog2(H + 1);
  localparam int unsigned AccW = 2 * WIDTH;
  localparam int unsigned ShW  = $clog2(AccW);

  localparam logic [2:0] OpAdd  = 3'd0;
  localparam logic [2:0] OpSub  = 3'd1;
  localparam logic [2:0] OpMul  = 3'd2;
  localparam logic [2:0] OpSqrt = 3'd3;

  localparam logic [WIDTH-1:0] MaxPos = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMulAcc, StSqrtIter, StFinish} state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   a_mag_q, a_mag_d;
  logic [WIDTH-1:0]   b_mag_q, b_mag_d;
  logic               neg_q, neg_d;
  logic [AccW-1:0]    acc_q, acc_d;
  logic [IdxW-1:0]    i_q, i_d;
  logic [IdxW-1:0]    j_q, j_d;
  logic [R-1:0]       rad_q, rad_d;
  logic [H-1:0]       rem_q, rem_d;
  logic [H-1:0]       root_q, root_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               overflow_q, overflow_d;
  logic               error_q, error_d;

  logic [N-1:0][MUL_CHUNK-1:0] a_chunks, b_chunks;
  logic [2*MUL_CHUNK-1:0]      prod;
  logic [ShW-1:0]              shift_amt;
  logic [WIDTH:0]              addsub;
  logic [AccW-1:0]             mul_mag;
  logic [AccW-1:0]             pos_lim;
  logic [AccW-1:0]             neg_lim;
  logic [RemW-1:0]             rem_shift;
  logic [RemW-1:0]             trial;
  logic                        root_bit;

  assign a_chunks = a_mag_q;
  assign b_chunks = b_mag_q;

  // The only multiplier in the design; operands selected by the chunk-pair counters.
  assign prod      = (2*MUL_CHUNK)'(a_chunks[i_q]) * (2*MUL_CHUNK)'(b_chunks[j_q]);
  assign shift_amt = ShW'(MUL_CHUNK) * (ShW'(i_q) + ShW'(j_q));

  assign addsub = (op_q == OpSub) ? ({a_q[WIDTH-1], a_q} - {b_q[WIDTH-1], b_q})
                                  : ({a_q[WIDTH-1], a_q} + {b_q[WIDTH-1], b_q});

  assign mul_mag = acc_q >> FBITS;
  assign pos_lim = AccW'(MaxPos);
  assign neg_lim = pos_lim + AccW'(1);

  assign rem_shift = {rem_q, rad_q[R-1:R-2]};
  assign trial     = {root_q, 2'b01};
  assign root_bit  = (rem_shift >= trial);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    a_mag_d    = a_mag_q;
    b_mag_d    = b_mag_q;
    neg_d      = neg_q;
    acc_d      = acc_q;
    i_d        = i_q;
    j_d        = j_q;
    rad_d      = rad_q;
    rem_d      = rem_q;
    root_d     = root_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    overflow_d = overflow_q;
    error_d    = error_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d       = operation;
          a_d        = operand_1;
          b_d        = operand_2;
          a_mag_d    = operand_1[WIDTH-1] ? -operand_1 : operand_1;
          b_mag_d    = operand_2[WIDTH-1] ? -operand_2 : operand_2;
          neg_d      = operand_1[WIDTH-1] ^ operand_2[WIDTH-1];
          acc_d      = '0;
          i_d        = '0;
          j_d        = '0;
          rad_d      = R'({operand_1, {FBITS{1'b0}}});
          rem_d      = '0;
          root_d     = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          overflow_d = 1'b0;
          error_d    = 1'b0;
          case (operation)
            OpMul:   state_d = StMulAcc;
            OpSqrt:  state_d = operand_1[WIDTH-1] ? StFinish : StSqrtIter;
            default: state_d = StFinish;
          endcase
        end
      end

      StMulAcc: begin
        acc_d = acc_q + (AccW'(prod) << shift_amt);
        if (j_q == IdxW'(N - 1)) begin
          j_d = '0;
          i_d = i_q + IdxW'(1);
          if (i_q == IdxW'(N - 1)) state_d = StFinish;
        end else begin
          j_d = j_q + IdxW'(1);
        end
      end

      StSqrtIter: begin
        // Restoring step: the top remainder bit can only be lost on the final iteration.
        rem_d  = root_bit ? H'(rem_shift - trial) : H'(rem_shift);
        root_d = {root_q[H-2:0], root_bit};
        rad_d  = rad_q << 2;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == CntW'(H - 1)) state_d = StFinish;
      end

      StFinish: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
        case (op_q)
          OpAdd, OpSub: begin
            if (addsub[WIDTH] != addsub[WIDTH-1]) begin
              result_d   = addsub[WIDTH] ? MinNeg : MaxPos;
              overflow_d = 1'b1;
            end else begin
              result_d = addsub[WIDTH-1:0];
            end
          end
          OpMul: begin
            if (neg_q && (mul_mag != '0)) begin
              if (mul_mag > neg_lim) begin
                result_d   = MinNeg;
                overflow_d = 1'b1;
              end else begin
                result_d = -mul_mag[WIDTH-1:0];
              end
            end else if (mul_mag > pos_lim) begin
              result_d   = MaxPos;
              overflow_d = 1'b1;
            end else begin
              result_d = mul_mag[WIDTH-1:0];
            end
          end
          OpSqrt: begin
            if (a_q[WIDTH-1]) begin
              result_d = '0;
              error_d  = 1'b1;
            end else begin
              result_d = WIDTH'(root_q);
            end
          end
          default: begin
            result_d = '0;
            error_d  = 1'b1;
          end
        endcase
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      a_mag_q    <= '0;
      b_mag_q    <= '0;
      neg_q      <= 1'b0;
      acc_q      <= '0;
      i_q        <= '0;
      j_q        <= '0;
      rad_q      <= '0;
      rem_q      <= '0;
      root_q     <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      a_mag_q    <= a_mag_d;
      b_mag_q    <= b_mag_d;
      neg_q      <= neg_d;
      acc_q      <= acc_d;
      i_q        <= i_d;
      j_q        <= j_d;
      rad_q      <= rad_d;
      rem_q      <= rem_d;
      root_q     <= root_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      error_q    <= error_d;
    end
  end

  assign result   = result_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign error    = error_q;

endmodule
